// File: rtl/blift_pkg.sv
// Shared definitions for the B-lift sequencing logic: default sizes, the
// sequencer state encoding and the per-product tag carried alongside the multiplier.
package blift_pkg;

    localparam int DEF_NUM_SHARES = 7;
    localparam int DEF_MUL_LAT    = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } seq_state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic is_final;
    } tag_t;

endpackage

// File: rtl/blift_tag_pipe.sv
// Fixed-latency tag delay line: a DEPTH-deep shift register of tag_t with
// asynchronous active-low clear, shared by the fixed-latency lift stages.
module blift_tag_pipe
    import blift_pkg::*;
#(
    parameter int DEPTH = DEF_MUL_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    // NOTE: every stage is cleared, not just the head, so a reset mid-run cannot
    // let stale tags mark untagged products as valid after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take its
            // predecessor's pre-edge value, so the tag moves one stage per clock.
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/blift_seq_ctrl.sv
// B-lift constant-multiply sequencer: issues every RNS share of every coefficient
// and tags the products. Optional abort support is enabled by BLIFT_SEQ_ABORT_EN.
module blift_seq_ctrl
    import blift_pkg::*;
#(
    parameter int NUM_SHARES = DEF_NUM_SHARES,
    parameter int NUM_COEFF  = 4096,
    parameter int CADDR_W    = 12,
    parameter int MUL_LAT    = DEF_MUL_LAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
`ifdef BLIFT_SEQ_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               busy,
    output logic               done,
    output logic [CADDR_W-1:0] coeff_addr,
    output logic [2:0]         share_idx,
    output logic               issue,
    output logic               prod_valid,
    output logic               prod_first,
    output logic               prod_last,
    output logic               prod_final
);

    localparam int                 CNT_W       = $clog2(MUL_LAT + 1);
    localparam logic [CADDR_W-1:0] LAST_COEFF  = CADDR_W'(NUM_COEFF - 1);
    localparam logic [2:0]         LAST_SHARE  = 3'(NUM_SHARES - 1);
    localparam logic [CNT_W-1:0]   DRAIN_FULL  = CNT_W'(MUL_LAT - 1);
    // An abort cycle issues nothing, so the last product is one cycle closer.
    localparam logic [CNT_W-1:0]   DRAIN_ABORT = CNT_W'(MUL_LAT - 2);

    seq_state_e         state, state_nxt;
    logic [CADDR_W-1:0] coeff_nxt;
    logic [2:0]         share_nxt;
    logic [CNT_W-1:0]   drain_cnt, drain_nxt;
    logic               abort_req;
    logic               last_pair;
    tag_t               tag_in, tag_out;

`ifdef BLIFT_SEQ_ABORT_EN
    logic abort_run;

    assign abort_req = abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_run <= 1'b0;
        end else if (state == IDLE && start) begin
            abort_run <= 1'b0;
        end else if (state == ISSUE && abort) begin
            abort_run <= 1'b1;
        end
    end

    assign aborted = abort_run && (state == IDLE || done);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            coeff_addr <= '0;
            share_idx  <= '0;
            drain_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            coeff_addr <= coeff_nxt;
            share_idx  <= share_nxt;
            drain_cnt  <= drain_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        coeff_nxt = coeff_addr;
        share_nxt = share_idx;
        drain_nxt = drain_cnt;
        issue     = 1'b0;
        done      = 1'b0;
        last_pair = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    coeff_nxt = '0;
                    share_nxt = '0;
                end
            end
            ISSUE: begin
                if (abort_req) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_ABORT;
                end else if (!(pause && share_idx == 3'd0)) begin
                    issue = 1'b1;
                    if (share_idx == LAST_SHARE) begin
                        share_nxt = '0;
                        if (coeff_addr == LAST_COEFF) begin
                            last_pair = 1'b1;
                            coeff_nxt = '0;
                            state_nxt = DRAIN;
                            drain_nxt = DRAIN_FULL;
                        end else begin
                            coeff_nxt = coeff_addr + 1'b1;
                        end
                    end else begin
                        share_nxt = share_idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    drain_nxt = drain_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    assign tag_in = '{
        valid:    issue,
        first:    issue && share_idx == 3'd0,
        last:     issue && share_idx == LAST_SHARE,
        is_final: last_pair
    };

    blift_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign prod_valid = tag_out.valid;
    assign prod_first = tag_out.first;
    assign prod_last  = tag_out.last;
    assign prod_final = tag_out.is_final;

endmodule
